// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// the default operand width and the 1-bit full-subtractor equations.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Difference bit of a - b - br
  function automatic logic fs_diff(input logic a, input logic b, input logic br);
    return a ^ b ^ br;
  endfunction

  // Borrow out of a - b - br: borrow when a=0,b=1, or when a==b and a borrow came in
  function automatic logic fs_borrow(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

endpackage

// File: rtl/fs_bit_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
module fs_bit_cell
  import serial_sub_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = fs_diff(a_i, b_i, bin_i);
  assign bout_o = fs_borrow(a_i, b_i, bin_i);

endmodule

// File: rtl/serial_subtractor_seq.sv
// Bit-serial WIDTH-bit subtractor computing a - b - bin, LSB first, one bit
// per clock through a single fs_bit_cell with a registered borrow loop.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor_seq
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic               br_q, br_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               ovf_q, ovf_d;
`endif

  logic cell_d;
  logic cell_bout;
  logic last_bit;

  // The single subtractor cell always sees the current LSBs and the borrow register
  fs_bit_cell u_cell (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .bin_i  (br_q),
    .d_o    (cell_d),
    .bout_o (cell_bout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state and datapath update: load on accept, shift one bit per SHIFT cycle
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      ST_SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = cell_bout;
        // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB
        diff_d = (diff_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = ST_DONE;
          bout_d  = cell_bout;
`ifdef SERIAL_SUB_OVF_EN
          // cell_d is the final result MSB on the last bit
          ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ cell_d);
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that aborts any operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
